// File: rtl/masked_serial_incrementer.sv
// masked_serial_incrementer
//   Bit-serial first-order masked incrementer. Adds a shared 1-bit carry-in to
//   a shared WIDTH-bit operand, LSB first, one bit per step cycle, through a
//   single half_adder_masked instance. The shares are never recombined.
//
// Parameters
//   WIDTH      operand width in bits (>= 2)
//   LFSR_SEED  reset value of the internal randomness LFSR (0 maps to 16'h0001)
//
// Ports
//   clk, rst              clock (rising edge), synchronous active-high reset
//   i_start               start request, sampled only in IDLE
//   i_a0, i_a1            operand shares, a = a0 ^ a1
//   i_cin0, i_cin1        carry-in shares, cin = cin0 ^ cin1
//   i_rnd, i_rnd_valid    external random bit + valid (MASKED_INC_EXT_RAND_EN only)
//   o_rnd_req             randomness requested, high in RUN (MASKED_INC_EXT_RAND_EN only)
//   o_busy                high in RUN and DONE
//   o_done                one-cycle completion pulse
//   o_sum0, o_sum1        result shares, sum = (a + cin) mod 2^WIDTH
//   o_cout0, o_cout1      carry-out shares
//
// Build option
//   MASKED_INC_EXT_RAND_EN  take randomness from i_rnd/i_rnd_valid (steps stall
//                           while i_rnd_valid is low) instead of the internal LFSR.

module masked_serial_incrementer #(
  parameter int unsigned WIDTH     = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a0,
  input  logic [WIDTH-1:0] i_a1,
  input  logic             i_cin0,
  input  logic             i_cin1,
`ifdef MASKED_INC_EXT_RAND_EN
  input  logic             i_rnd,
  input  logic             i_rnd_valid,
  output logic             o_rnd_req,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum0,
  output logic [WIDTH-1:0] o_sum1,
  output logic             o_cout0,
  output logic             o_cout1
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_n;
  logic [WIDTH-1:0]   op0_q, op0_n, op1_q, op1_n;
  logic [WIDTH-1:0]   res0_q, res0_n, res1_q, res1_n;
  logic               cy0_q, cy0_n, cy1_q, cy1_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               busy_n, done_n;
  logic [WIDTH-1:0]   sum0_n, sum1_n;
  logic               cout0_n, cout1_n;

  logic               step_c;
  logic               rn_c;
  logic               ha_s0_c, ha_s1_c, ha_c0_c, ha_c1_c;

`ifdef MASKED_INC_EXT_RAND_EN
  logic               rnd_req_n;

  // A step consumes the presented external bit; no valid bit means a stall.
  assign step_c = (state_q == ST_RUN) && i_rnd_valid;
  assign rn_c   = i_rnd;
`else
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  logic [15:0]        lfsr_q, lfsr_n;
  logic               lfsr_fb_c;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting right; bit 0 is the fresh bit.
  assign lfsr_fb_c = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign step_c    = (state_q == ST_RUN);
  assign rn_c      = lfsr_q[0];
`endif

  // Single shared half adder; its outputs only ever feed registers.
  half_adder_masked u_ha (
    .a0     (op0_q[0]),
    .a1     (op1_q[0]),
    .b0     (cy0_q),
    .b1     (cy1_q),
    .rN     (rn_c),
    .sum0   (ha_s0_c),
    .sum1   (ha_s1_c),
    .carry0 (ha_c0_c),
    .carry1 (ha_c1_c)
  );

  // Next-state and next-register values.
  always_comb begin
    state_n = state_q;
    op0_n   = op0_q;
    op1_n   = op1_q;
    res0_n  = res0_q;
    res1_n  = res1_q;
    cy0_n   = cy0_q;
    cy1_n   = cy1_q;
    cnt_n   = cnt_q;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    sum0_n  = o_sum0;
    sum1_n  = o_sum1;
    cout0_n = o_cout0;
    cout1_n = o_cout1;
`ifndef MASKED_INC_EXT_RAND_EN
    lfsr_n  = lfsr_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          op0_n   = i_a0;
          op1_n   = i_a1;
          cy0_n   = i_cin0;
          cy1_n   = i_cin1;
          cnt_n   = '0;
          state_n = ST_RUN;
          busy_n  = 1'b1;
        end
      end

      ST_RUN: begin
        busy_n = 1'b1;
        if (step_c) begin
          // Result bits enter at the MSB so the first bit ends up at bit 0.
          res0_n = {ha_s0_c, res0_q[WIDTH-1:1]};
          res1_n = {ha_s1_c, res1_q[WIDTH-1:1]};
          cy0_n  = ha_c0_c;
          cy1_n  = ha_c1_c;
          op0_n  = op0_q >> 1;
          op1_n  = op1_q >> 1;
          cnt_n  = cnt_q + CNT_W'(1);
`ifndef MASKED_INC_EXT_RAND_EN
          lfsr_n = {lfsr_fb_c, lfsr_q[15:1]};
`endif
          // Publish on the last step so outputs and o_done are valid in DONE.
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_n = ST_DONE;
            done_n  = 1'b1;
            sum0_n  = res0_n;
            sum1_n  = res1_n;
            cout0_n = ha_c0_c;
            cout1_n = ha_c1_c;
          end
        end
      end

      ST_DONE: begin
        state_n = ST_IDLE;
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

`ifdef MASKED_INC_EXT_RAND_EN
  assign rnd_req_n = (state_n == ST_RUN);
`endif

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op0_q   <= '0;
      op1_q   <= '0;
      res0_q  <= '0;
      res1_q  <= '0;
      cy0_q   <= 1'b0;
      cy1_q   <= 1'b0;
      cnt_q   <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_sum0  <= '0;
      o_sum1  <= '0;
      o_cout0 <= 1'b0;
      o_cout1 <= 1'b0;
`ifdef MASKED_INC_EXT_RAND_EN
      o_rnd_req <= 1'b0;
`else
      lfsr_q  <= SEED_EFF;
`endif
    end else begin
      state_q <= state_n;
      op0_q   <= op0_n;
      op1_q   <= op1_n;
      res0_q  <= res0_n;
      res1_q  <= res1_n;
      cy0_q   <= cy0_n;
      cy1_q   <= cy1_n;
      cnt_q   <= cnt_n;
      o_busy  <= busy_n;
      o_done  <= done_n;
      o_sum0  <= sum0_n;
      o_sum1  <= sum1_n;
      o_cout0 <= cout0_n;
      o_cout1 <= cout1_n;
`ifdef MASKED_INC_EXT_RAND_EN
      o_rnd_req <= rnd_req_n;
`else
      lfsr_q  <= lfsr_n;
`endif
    end
  end

endmodule

// half_adder_masked
//   First-order masked half adder. Sum shares are share-wise XORs; the AND for
//   the carry uses one fresh bit rN to re-mask the cross terms.
// Ports
//   a0, a1 / b0, b1   input shares
//   rN                fresh random bit
//   sum0, sum1        shares of a ^ b
//   carry0, carry1    shares of a & b
module half_adder_masked (
  input  logic a0,
  input  logic a1,
  input  logic b0,
  input  logic b1,
  input  logic rN,
  output logic sum0,
  output logic sum1,
  output logic carry0,
  output logic carry1
);

  assign sum0 = a0 ^ b0;
  assign sum1 = a1 ^ b1;

  // Each cross term is masked by rN before meeting the same-domain product.
  assign carry0 = (a0 & b0) ^ ((a0 & b1) ^ rN);
  assign carry1 = (a1 & b1) ^ ((a1 & b0) ^ rN);

endmodule

// File: tb/tb_masked_serial_incrementer.sv
// Directed bench for masked_serial_incrementer (default build, WIDTH=8).
module tb_masked_serial_incrementer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_start;
  logic [W-1:0] i_a0, i_a1;
  logic         i_cin0, i_cin1;
  logic         o_busy, o_done;
  logic [W-1:0] o_sum0, o_sum1;
  logic         o_cout0, o_cout1;

  int total = 0;
  int bad   = 0;

  masked_serial_incrementer #(.WIDTH(W), .LFSR_SEED(16'hACE1)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_start (i_start),
    .i_a0    (i_a0),
    .i_a1    (i_a1),
    .i_cin0  (i_cin0),
    .i_cin1  (i_cin1),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_sum0  (o_sum0),
    .o_sum1  (o_sum1),
    .o_cout0 (o_cout0),
    .o_cout1 (o_cout1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start one operation and watch cycles 1..12 after the accepting edge.
  // strobe_cyc > 0 re-asserts i_start during that cycle of the run.
  task automatic do_op(input string tag, input logic [W-1:0] a0, input logic [W-1:0] a1,
                       input logic c0, input logic c1, input logic [W-1:0] exp_sum,
                       input logic exp_cout, input int strobe_cyc,
                       output logic cout0_seen);
    int done_cyc;
    int done_cnt;
    @(negedge clk);
    i_a0 = a0; i_a1 = a1; i_cin0 = c0; i_cin1 = c1; i_start = 1'b1;
    @(negedge clk);
    i_start  = 1'b0;
    done_cyc = 0;
    done_cnt = 0;
    cout0_seen = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      chk({tag, "_busy"}, 32'(o_busy), 32'(k <= int'(W) + 1));
      if (o_done === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = k;
      end
      if (k == int'(W) + 1) begin
        chk({tag, "_sum"}, 32'(o_sum0 ^ o_sum1), 32'(exp_sum));
        chk({tag, "_cout"}, 32'(o_cout0 ^ o_cout1), 32'(exp_cout));
        cout0_seen = o_cout0;
      end
      i_start = (k == strobe_cyc);
      @(negedge clk);
      i_start = 1'b0;
    end
    chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(W + 1));
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_hold_sum"}, 32'(o_sum0 ^ o_sum1), 32'(exp_sum));
  endtask

  initial begin
    logic         c0s, first_c0;
    logic         differs;
    logic [W-1:0] ra, rm;
    logic         rc0, rc1;
    int           dcnt;

    rst = 1'b1; i_start = 1'b0; i_a0 = '0; i_a1 = '0; i_cin0 = 1'b0; i_cin1 = 1'b0;
    repeat (3) @(negedge clk);
    // Reset state
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_sum0", 32'(o_sum0), 32'd0);
    chk("rst_sum1", 32'(o_sum1), 32'd0);
    chk("rst_cout", 32'({o_cout0, o_cout1}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors
    do_op("v5a", 8'h66, 8'h3C, 1'b1, 1'b0, 8'h5B, 1'b0, 0, c0s);
    do_op("vff", 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 0, c0s);
    do_op("v26", 8'h12, 8'h34, 1'b1, 1'b1, 8'h26, 1'b0, 0, c0s);
    do_op("v80", 8'h80, 8'h7F, 1'b0, 1'b0, 8'hFF, 1'b0, 0, c0s);
    do_op("v00", 8'hA5, 8'hA5, 1'b0, 1'b1, 8'h01, 1'b0, 0, c0s);
    // Second start in cycle 4 must be ignored
    do_op("strb", 8'h66, 8'h3C, 1'b1, 1'b0, 8'h5B, 1'b0, 4, c0s);

    // Reset in cycle 5 aborts the run
    @(negedge clk);
    i_a0 = 8'h0F; i_a1 = 8'hF0; i_cin0 = 1'b1; i_cin1 = 1'b0; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_done", 32'(o_done), 32'd0);
    chk("abort_sum", 32'({o_sum0, o_sum1}), 32'd0);
    chk("abort_cout", 32'({o_cout0, o_cout1}), 32'd0);
    dcnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (o_done === 1'b1) dcnt++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(dcnt), 32'd0);
    do_op("post_rst", 8'h0F, 8'hF0, 1'b1, 1'b0, 8'h00, 1'b1, 0, c0s);

    // Same operand, advancing LFSR: carry shares must vary, value must not
    differs = 1'b0;
    do_op("mask0", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 0, first_c0);
    for (int r = 0; r < 8; r++) begin
      do_op("maskn", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 0, c0s);
      if (c0s !== first_c0) differs = 1'b1;
    end
    chk("cout_share_vary", 32'(differs), 32'd1);

    // Random operands, masks and carry-in
    for (int n = 0; n < 256; n++) begin
      ra  = W'($urandom);
      rm  = W'($urandom);
      rc0 = 1'($urandom);
      rc1 = 1'($urandom);
      do_op("rand", ra ^ rm, rm, rc0, rc1, W'(ra + W'(rc0 ^ rc1)),
            (ra == {W{1'b1}}) && (rc0 ^ rc1), 0, c0s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/masked_serial_incrementer.md
# masked_serial_incrementer

Bit-serial first-order masked incrementer: adds a shared 1-bit carry-in to a shared WIDTH-bit operand by running one `half_adder_masked` instance over the operand, LSB first, one bit per cycle. Owns the datapath scheduling, the registered carry shares between bits, and the supply of one fresh random bit (`rN`) per half-adder evaluation. Sits between the masked-operand producer and the registered PROLEAD-checked output stage; all outputs are registered.

## Interface

- `WIDTH`, 8, operand width in bits (≥2).
- `LFSR_SEED`, 16'hACE1, internal LFSR reset value; 0 is replaced by 16'h0001.

- `clk` input 1 — single clock, rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `i_start` input 1 — start request; sampled only in IDLE.
- `i_a0`, `i_a1` input WIDTH — operand shares; a = a0 ^ a1.
- `i_cin0`, `i_cin1` input 1 — carry-in shares; cin = cin0 ^ cin1.
- `i_rnd` input 1 — external random bit (only with `MASKED_INC_EXT_RAND_EN`).
- `i_rnd_valid` input 1 — `i_rnd` valid (only with `MASKED_INC_EXT_RAND_EN`).
- `o_rnd_req` output 1 — randomness requested this cycle (only with `MASKED_INC_EXT_RAND_EN`).
- `o_busy` output 1 — high in RUN and DONE.
- `o_done` output 1 — one-cycle completion pulse.
- `o_sum0`, `o_sum1` output WIDTH — result shares; sum = (a + cin) mod 2^WIDTH.
- `o_cout0`, `o_cout1` output 1 — carry-out shares.

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE: if `i_start`, capture `i_a0`/`i_a1` into shift registers, load carry registers with `i_cin0`/`i_cin1`, clear bit counter, go to RUN. Otherwise stay.
- RUN, step cycle (randomness available): drive the half adder with a0 = operand share 0 bit[0], a1 = operand share 1 bit[0], b0/b1 = carry registers, rN = current random bit. Register sum0/sum1 into the result shift registers (shift in at MSB, shift right). Register carry0/carry1 into the carry registers. Shift the operand registers right and increment the counter.
- RUN: after WIDTH step cycles, go to DONE.
- DONE: copy the result shift registers to `o_sum0`/`o_sum1` and the carry registers to `o_cout0`/`o_cout1`. Pulse `o_done`, then return to IDLE.
- Outputs hold their value until the next DONE. Intermediate bits never appear on the outputs.
- Shares are never recombined anywhere in the block. Each random bit is used for exactly one half-adder evaluation.
- `i_start` in RUN or DONE is ignored; it is not queued.
- Reset, including mid-operation: state IDLE; `o_busy`, `o_done`, `o_sum0`, `o_sum1`, `o_cout0`, `o_cout1` = 0; shift, carry and counter registers = 0; LFSR = seed. An aborted operation produces no `o_done`.

## Timing

- `i_start` accepted at edge 0 → step cycles 1..WIDTH with no stalls → `o_done` high and outputs valid in cycle WIDTH+1. Latency is WIDTH+1 cycles.
- `o_busy` is high from cycle 1 through cycle WIDTH+1.
- The earliest next start is accepted in cycle WIDTH+2.
- Throughput is one operation per WIDTH+2 cycles.
- Half-adder outputs are consumed only through registers. There is no combinational path from inputs to outputs.

## Configuration

- `MASKED_INC_EXT_RAND_EN` defined:
  - `i_rnd`, `i_rnd_valid` and `o_rnd_req` exist.
  - `o_rnd_req` = 1 in RUN.
  - A step happens only when `i_rnd_valid` = 1, with rN = `i_rnd`.
  - Otherwise it is a stall: no register changes and the counter holds.
  - Latency becomes WIDTH+1+stall cycles.
- Not defined:
  - Those ports are absent.
  - rN = bit 0 of an internal 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
  - The LFSR advances exactly once per step cycle and holds otherwise.
  - No stalls occur.

## Test plan

- WIDTH=8, a0=0x66, a1=0x3C (a=0x5A), cin0=1, cin1=0 → `o_done` in cycle 9; sum0^sum1 = 0x5B; cout0^cout1 = 0.
- a0=0xFF, a1=0x00, cin0=0, cin1=1 → sum = 0x00, cout = 1, `o_busy` high for cycles 1–9.
- `i_start` pulsed again in cycle 4 of a run → ignored; a single `o_done` in cycle 9; result unchanged.
- `rst` asserted in cycle 5 of a run → next cycle all outputs 0, IDLE, no `o_done`; a new start then completes normally.
- With `MASKED_INC_EXT_RAND_EN`, `i_rnd_valid` low for 3 cycles mid-run → `o_done` in cycle 12 and the correct unmasked sum.
- 256 operands with random masks and cin → unmasked sum/cout match a+cin. With a fixed operand and a different LFSR state, carry shares differ while the unmasked value is unchanged.
